// File: rtl/tag_mem_pkg.sv
// Tag memory controller shared types.
// Op codes, FSM states and bank select positions.
package tag_mem_pkg;

  typedef enum logic [1:0] {
    OP_RD_EPC  = 2'd0,
    OP_RD_SENS = 2'd1,
    OP_WR_EPC  = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHG,
    S_ACCESS,
    S_LATCH,
    S_SHIFT
  } state_e;

  typedef enum logic [1:0] {
    K_LOG,
    K_RD,
    K_WR
  } kind_e;

  localparam int SEL_EPC   = 0;
  localparam int SEL_SENS0 = 1;

endpackage

// File: rtl/tag_tx_serializer.sv
// LSB-first word serializer for the backscatter TX path.
// Emits prefetch phase strobes so the next word lands gaplessly.
module tag_tx_serializer
  import tag_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              data_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_word,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              pf_req,
  output logic              pf_acc,
  output logic              pf_cap,
  output logic              pf_next
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] I_END = IW'(DATA_W - 1);
  localparam logic [IW-1:0] I_PRE = IW'(DATA_W - 4);
  localparam logic [IW-1:0] I_ACC = IW'(DATA_W - 3);
  localparam logic [IW-1:0] I_CAP = IW'(DATA_W - 2);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              act_q, act_d;
  logic              last_q, last_d;
  logic              word_end;

  assign word_end = act_q && (idx_q == I_END);
  assign tx_bit   = act_q & sh_q[0];
  assign tx_valid = act_q;
  assign tx_last  = word_end && last_q;
  assign pf_req   = act_q && !last_q && (idx_q == I_PRE);
  assign pf_acc   = act_q && !last_q && (idx_q == I_ACC);
  assign pf_cap   = act_q && !last_q && (idx_q == I_CAP);
  assign pf_next  = word_end && !last_q;

  // shift one bit per cycle; load or clear override
  always_comb begin
    sh_d   = sh_q;
    idx_d  = idx_q;
    act_d  = act_q;
    last_d = last_q;
    if (act_q) begin
      sh_d  = sh_q >> 1;
      idx_d = idx_q + IW'(1);
      if (word_end) act_d = 1'b0;
    end
    if (load) begin
      sh_d   = load_word;
      idx_d  = '0;
      act_d  = 1'b1;
      last_d = load_last;
    end
    if (clear) begin
      sh_d   = '0;
      idx_d  = '0;
      act_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // serializer state register
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tag_mem_ctrl_gen.sv
// Tag memory controller: EPC bank plus sensor ring buffers
// arbitrated onto one precharged SRAM port, serial TX out.
module tag_mem_ctrl_gen
  import tag_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int N_SENS = 2
) (
  input  logic                       data_clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [2:0]                 cmd_ch,
  input  logic [ADDR_W-1:0]          cmd_ptr,
  input  logic [ADDR_W:0]            cmd_count,
  input  logic [DATA_W-1:0]          cmd_wdata,
  input  logic                       cmd_abort,
  input  logic [N_SENS-1:0]          adc_valid,
  input  logic [N_SENS*DATA_W-1:0]   adc_data,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_pcb,
  output logic                       mem_we,
  output logic                       mem_se,
  output logic [N_SENS:0]            mem_sel,
  output logic                       tx_bit,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       done,
  output logic                       err,
  output logic [N_SENS*(ADDR_W+1)-1:0] fill,
  output logic [N_SENS-1:0]          overflow,
  output logic [N_SENS-1:0]          lost
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = N_SENS + 1;
  localparam int EW = ADDR_W + 2;
  localparam int DEPTH_I = 1 << ADDR_W;
  localparam logic [CW-1:0] DEPTH = CW'(DEPTH_I);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [SW-1:0]     bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        log_ch_q, log_ch_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] wr_ptr_q [N_SENS];
  logic [ADDR_W-1:0] wr_ptr_d [N_SENS];
  logic [CW-1:0]     fill_q   [N_SENS];
  logic [CW-1:0]     fill_d   [N_SENS];
  logic [DATA_W-1:0] samp_q   [N_SENS];
  logic [DATA_W-1:0] samp_d   [N_SENS];
  logic [N_SENS-1:0] pend_q, pend_d;
  logic [N_SENS-1:0] ovf_q, ovf_d;
  logic [N_SENS-1:0] lost_q, lost_d;

  logic              commit;
  logic              abort_act;
  logic              ser_load, ser_last;
  logic [DATA_W-1:0] ser_word;
  logic              pf_req, pf_acc, pf_cap, pf_next;

  logic              c_ok;
  logic [CW-1:0]     c_fill, n_rd;
  logic [ADDR_W-1:0] c_ptr;
  logic [2:0]        lo_ch;
  logic [ADDR_W-1:0] lo_ptr;
  logic [DATA_W-1:0] lo_samp;
  logic [EW-1:0]     epc_end;
  logic              epc_bad;
  logic [ADDR_W-1:0] addr_nxt;

  function automatic logic [SW-1:0] sens_sel(
    input logic [2:0] ch
  );
    sens_sel = '0;
    for (int i = 0; i < N_SENS; i++)
      if (ch == 3'(i)) sens_sel[SEL_SENS0 + i] = 1'b1;
  endfunction

  assign abort_act = cmd_abort && (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && !(|pend_q)
                     && !(|adc_valid);
  assign epc_end   = EW'(cmd_ptr) + EW'(cmd_count);
  assign epc_bad   = (cmd_count == '0) || (epc_end > EW'(DEPTH_I));
  assign n_rd      = (cmd_count < c_fill) ? cmd_count : c_fill;
  assign addr_nxt  = desc_q ? addr_q - ADDR_W'(1)
                            : addr_q + ADDR_W'(1);
  assign done      = done_q;
  assign err       = err_q;
  assign overflow  = ovf_q;
  assign lost      = lost_q;

  for (genvar g = 0; g < N_SENS; g++) begin : g_fill
    assign fill[g*CW +: CW] = fill_q[g];
  end

  // channel lookups: lowest pending log and commanded channel
  always_comb begin
    c_ok    = 1'b0;
    c_fill  = '0;
    c_ptr   = '0;
    lo_ch   = '0;
    lo_ptr  = '0;
    lo_samp = '0;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_ch   = 3'(i);
        lo_ptr  = wr_ptr_q[i];
        lo_samp = samp_q[i];
      end
    end
    for (int i = 0; i < N_SENS; i++) begin
      if (cmd_ch == 3'(i)) begin
        c_ok   = 1'b1;
        c_fill = fill_q[i];
        c_ptr  = wr_ptr_q[i];
      end
    end
  end

  // main sequencer: arbitration, macro phases, word fetch
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    desc_d   = desc_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    log_ch_d = log_ch_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;
    ser_load = 1'b0;
    ser_last = 1'b0;
    ser_word = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          kind_d   = K_LOG;
          log_ch_d = lo_ch;
          bank_d   = sens_sel(lo_ch);
          addr_d   = lo_ptr;
          wdata_d  = lo_samp;
          state_d  = S_PRECHG;
        end else if (cmd_valid && cmd_ready) begin
          unique case (op_e'(cmd_op))
            OP_RD_EPC: begin
              if (epc_bad) begin
                err_d = 1'b1;
              end else begin
                kind_d  = K_RD;
                bank_d  = SW'(1) << SEL_EPC;
                addr_d  = cmd_ptr;
                rem_d   = cmd_count;
                desc_d  = 1'b0;
                state_d = S_PRECHG;
              end
            end
            OP_RD_SENS: begin
              if (!c_ok || n_rd == '0) begin
                err_d = 1'b1;
              end else begin
                kind_d  = K_RD;
                bank_d  = sens_sel(cmd_ch);
                addr_d  = c_ptr - ADDR_W'(1);
                rem_d   = n_rd;
                desc_d  = 1'b1;
                state_d = S_PRECHG;
              end
            end
            OP_WR_EPC: begin
              kind_d  = K_WR;
              bank_d  = SW'(1) << SEL_EPC;
              addr_d  = cmd_ptr;
              wdata_d = cmd_wdata;
              state_d = S_PRECHG;
            end
            OP_RSVD: err_d = 1'b1;
          endcase
        end
      end
      S_PRECHG: state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_LATCH;
        if (kind_q == K_WR) done_d = 1'b1;
      end
      S_LATCH: begin
        state_d = S_IDLE;
        if (kind_q == K_RD) begin
          ser_load = 1'b1;
          ser_word = mem_rdata;
          ser_last = (rem_q == CW'(1));
          rem_d    = rem_q - CW'(1);
          addr_d   = addr_nxt;
          state_d  = S_SHIFT;
        end else if (kind_q == K_LOG) begin
          commit = 1'b1;
        end
      end
      S_SHIFT: begin
        if (pf_cap) rdata_d = mem_rdata;
        if (pf_next) begin
          ser_load = 1'b1;
          ser_last = (rem_q == CW'(1));
          rem_d    = rem_q - CW'(1);
          addr_d   = addr_nxt;
        end
        if (tx_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      err_d    = 1'b0;
      commit   = 1'b0;
      ser_load = 1'b0;
    end
  end

  // ring pointers, fill, pending samples and sticky flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    samp_d   = samp_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    lost_d   = lost_q;
    for (int i = 0; i < N_SENS; i++) begin
      if (commit && log_ch_q == 3'(i)) begin
        wr_ptr_d[i] = wr_ptr_q[i] + ADDR_W'(1);
        pend_d[i]   = 1'b0;
        if (fill_q[i] == DEPTH) ovf_d[i] = 1'b1;
        else fill_d[i] = fill_q[i] + CW'(1);
      end
      if (adc_valid[i]) begin
        if (pend_q[i]) begin
          lost_d[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          samp_d[i] = adc_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // macro port strobes decoded from sequencer and prefetch phase
  always_comb begin
    mem_pcb   = 1'b1;
    mem_we    = 1'b0;
    mem_se    = 1'b0;
    mem_addr  = '0;
    mem_sel   = '0;
    mem_wdata = '0;
    if ((state_q == S_PRECHG) || (state_q == S_ACCESS)
        || (state_q == S_LATCH)
        || ((state_q == S_SHIFT)
            && (pf_req || pf_acc || pf_cap))) begin
      mem_addr = addr_q;
      mem_sel  = bank_q;
    end
    if ((state_q == S_PRECHG)
        || ((state_q == S_SHIFT) && pf_req))
      mem_pcb = 1'b0;
    if (state_q == S_ACCESS) begin
      if (kind_q == K_RD) begin
        mem_se = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
      end
    end
    if ((state_q == S_SHIFT) && pf_acc) mem_se = 1'b1;
  end

  // sequencer registers
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_LOG;
      bank_q   <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      desc_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      log_ch_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      desc_q   <= desc_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      log_ch_q <= log_ch_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // ring buffer registers
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SENS; i++) begin
        wr_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
        samp_q[i]   <= '0;
      end
      pend_q <= '0;
      ovf_q  <= '0;
      lost_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      samp_q   <= samp_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      lost_q   <= lost_d;
    end
  end

  tag_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .data_clk  (data_clk),
    .reset     (reset),
    .clear     (abort_act),
    .load      (ser_load),
    .load_last (ser_last),
    .load_word (ser_word),
    .tx_bit    (tx_bit),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .pf_req    (pf_req),
    .pf_acc    (pf_acc),
    .pf_cap    (pf_cap),
    .pf_next   (pf_next)
  );

endmodule

// File: tb/tb_tag_mem_ctrl_gen.sv
// Directed bench for tag_mem_ctrl_gen with an SRAM macro model.
// Hand-computed expectations for each command scenario.
module tb_tag_mem_ctrl_gen;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NS = 2;

  logic              data_clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [2:0]        cmd_ch = '0;
  logic [AW-1:0]     cmd_ptr = '0;
  logic [AW:0]       cmd_count = '0;
  logic [DW-1:0]     cmd_wdata = '0;
  logic              cmd_abort = 1'b0;
  logic [NS-1:0]     adc_valid = '0;
  logic [NS*DW-1:0]  adc_data = '0;
  logic [DW-1:0]     mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_pcb, mem_we, mem_se;
  logic [NS:0]       mem_sel;
  logic              tx_bit, tx_valid, tx_last;
  logic              done, err;
  logic [NS*(AW+1)-1:0] fill;
  logic [NS-1:0]     overflow, lost;

  tag_mem_ctrl_gen #(
    .DATA_W (DW), .ADDR_W (AW), .N_SENS (NS)
  ) dut (
    .data_clk  (data_clk),  .reset     (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),    .cmd_ch    (cmd_ch),
    .cmd_ptr   (cmd_ptr),   .cmd_count (cmd_count),
    .cmd_wdata (cmd_wdata), .cmd_abort (cmd_abort),
    .adc_valid (adc_valid), .adc_data  (adc_data),
    .mem_rdata (mem_rdata), .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata), .mem_pcb   (mem_pcb),
    .mem_we    (mem_we),    .mem_se    (mem_se),
    .mem_sel   (mem_sel),   .tx_bit    (tx_bit),
    .tx_valid  (tx_valid),  .tx_last   (tx_last),
    .done      (done),      .err       (err),
    .fill      (fill),      .overflow  (overflow),
    .lost      (lost)
  );

  always #5 data_clk = ~data_clk;

  logic [DW-1:0] mem_m [3][64];

  always @(posedge data_clk) begin
    for (int b = 0; b < 3; b++) begin
      if (mem_sel[b]) begin
        if (mem_we) mem_m[b][mem_addr] <= mem_wdata;
        if (mem_se) mem_rdata <= mem_m[b][mem_addr];
      end
    end
  end

  logic bits [$];
  int   n_done = 0, n_err = 0, n_pcb = 0, n_last = 0;
  int   run = 0, last_run = 0;

  always @(negedge data_clk) begin
    if (tx_valid) begin
      bits.push_back(tx_bit);
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (done) n_done++;
    if (err) n_err++;
    if (!mem_pcb) n_pcb++;
    if (tx_last) n_last++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int b);
    logic [DW-1:0] w;
    for (int k = 0; k < DW; k++) w[k] = bits[b + k];
    return w;
  endfunction

  task automatic issue(input logic [1:0] op,
                       input logic [2:0] ch,
                       input logic [AW-1:0] ptr,
                       input logic [AW:0] cnt,
                       input logic [DW-1:0] wd);
    bit ok;
    @(negedge data_clk);
    cmd_op = op; cmd_ch = ch; cmd_ptr = ptr;
    cmd_count = cnt; cmd_wdata = wd;
    cmd_valid = 1'b1;
    ok = cmd_ready;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge data_clk);
      ok = cmd_ready;
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge data_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    int  d0, e0;
    bit  hit;
    d0 = n_done; e0 = n_err; hit = 1'b0;
    for (int k = 0; k < lim && !hit; k++) begin
      @(negedge data_clk);
      #1;
      hit = (n_done != d0) || (n_err != e0);
    end
    if (!hit) chk("end_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int  b0, p0, e0, d0, l0, nb;
    bit  hit;
    repeat (3) @(negedge data_clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pcb", mem_pcb, 1);
    chk("rst_strobes", {mem_we, mem_se, tx_valid,
                        done, err}, 0);
    chk("rst_fill", fill, 0);
    reset = 1'b0;

    issue(2'd2, 3'd0, 6'd3, 7'd0, 16'hA5C3);
    wait_end(50);
    chk("wr_done", n_done, 1);
    b0 = bits.size(); l0 = n_last;
    issue(2'd0, 3'd0, 6'd3, 7'd1, 16'h0);
    wait_end(100);
    chk("rd3_word", word_at(b0), 16'hA5C3);
    chk("rd3_bits", bits.size() - b0, 16);
    chk("rd3_last", n_last - l0, 1);

    issue(2'd2, 3'd0, 6'd63, 7'd0, 16'h8001);
    wait_end(50);
    b0 = bits.size();
    issue(2'd0, 3'd0, 6'd63, 7'd1, 16'h0);
    wait_end(100);
    chk("rd63_edge", word_at(b0), 16'h8001);

    p0 = n_pcb; e0 = n_err; d0 = n_done;
    issue(2'd0, 3'd0, 6'd60, 7'd5, 16'h0);
    @(negedge data_clk); #1;
    chk("ovr_err", err, 1);
    chk("ovr_ready", cmd_ready, 1);
    issue(2'd0, 3'd0, 6'd0, 7'd0, 16'h0);
    wait_end(10);
    issue(2'd1, 3'd2, 6'd0, 7'd1, 16'h0);
    wait_end(10);
    issue(2'd3, 3'd0, 6'd0, 7'd1, 16'h0);
    wait_end(10);
    issue(2'd1, 3'd0, 6'd0, 7'd1, 16'h0);
    wait_end(10);
    chk("err_count", n_err - e0, 5);
    chk("err_no_pcb", n_pcb - p0, 0);
    chk("err_no_done", n_done - d0, 0);

    for (int k = 0; k <= 64; k++) begin
      @(negedge data_clk);
      adc_data[31:16] = 16'(k);
      adc_valid = 2'b10;
      @(negedge data_clk);
      adc_valid = 2'b00;
      repeat (5) @(negedge data_clk);
    end
    chk("fill1_sat", fill[13:7], 7'd64);
    chk("fill0_zero", fill[6:0], 7'd0);
    chk("ovf", overflow, 2'b10);
    chk("lost_none", lost, 2'b00);
    chk("log_no_done", n_done - d0, 0);

    b0 = bits.size(); l0 = n_last;
    issue(2'd1, 3'd1, 6'd0, 7'd3, 16'h0);
    wait_end(200);
    chk("sens_w0", word_at(b0), 16'd64);
    chk("sens_w1", word_at(b0 + 16), 16'd63);
    chk("sens_w2", word_at(b0 + 32), 16'd62);
    chk("sens_run", last_run, 48);
    chk("sens_last", n_last - l0, 1);
    chk("sens_fill", fill[13:7], 7'd64);

    b0 = bits.size();
    issue(2'd0, 3'd0, 6'd3, 7'd1, 16'h0);
    @(negedge data_clk);
    adc_data[15:0] = 16'h0111; adc_valid = 2'b01;
    @(negedge data_clk);
    adc_valid = 2'b00;
    @(negedge data_clk);
    adc_data[15:0] = 16'h0222; adc_valid = 2'b01;
    @(negedge data_clk);
    adc_valid = 2'b00;
    wait_end(100);
    chk("lost_word", word_at(b0), 16'hA5C3);
    chk("lost_fill_at_done", fill[6:0], 7'd0);
    chk("lost_flag", lost, 2'b01);
    repeat (8) @(negedge data_clk);
    chk("lost_fill_after", fill[6:0], 7'd1);
    b0 = bits.size();
    issue(2'd1, 3'd0, 6'd0, 7'd4, 16'h0);
    wait_end(100);
    chk("lost_logged", word_at(b0), 16'h0111);
    chk("lost_nwords", bits.size() - b0, 16);

    d0 = n_done; e0 = n_err;
    @(negedge data_clk);
    cmd_op = 2'd0; cmd_ptr = 6'd3; cmd_count = 7'd1;
    adc_data[15:0] = 16'h0333;
    adc_valid = 2'b01; cmd_valid = 1'b1;
    #1 chk("simul_ready", cmd_ready, 0);
    @(posedge data_clk);
    #1 cmd_valid = 1'b0; adc_valid = 2'b00;
    repeat (10) @(negedge data_clk);
    chk("simul_fill", fill[6:0], 7'd2);
    chk("simul_no_pulse", (n_done - d0) + (n_err - e0), 0);

    issue(2'd2, 3'd0, 6'd0, 7'd0, 16'h1234);
    wait_end(50);
    issue(2'd2, 3'd0, 6'd1, 7'd0, 16'hBEEF);
    wait_end(50);
    d0 = n_done; e0 = n_err;
    issue(2'd0, 3'd0, 6'd0, 7'd2, 16'h0);
    nb = 0; hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge data_clk);
      if (tx_valid) nb++;
      hit = (nb == 8);
    end
    chk("abort_reach", hit, 1);
    cmd_abort = 1'b1;
    @(negedge data_clk);
    chk("abort_txv", tx_valid, 0);
    chk("abort_mem", {mem_pcb, mem_we, mem_se}, 3'b100);
    cmd_abort = 1'b0;
    repeat (40) @(negedge data_clk);
    chk("abort_no_done", (n_done - d0) + (n_err - e0), 0);
    b0 = bits.size();
    issue(2'd0, 3'd0, 6'd1, 7'd1, 16'h0);
    wait_end(100);
    chk("abort_recover", word_at(b0), 16'hBEEF);
    chk("abort_done", n_done - d0, 1);

    issue(2'd2, 3'd0, 6'd5, 7'd0, 16'h5555);
    @(posedge data_clk);
    #2 chk("acc_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_pcb2", mem_pcb, 1);
    chk("rst_fill2", fill, 0);
    chk("rst_flags", {overflow, lost}, 0);
    chk("rst_ready2", cmd_ready, 1);
    @(negedge data_clk);
    reset = 1'b0;
    b0 = bits.size();
    issue(2'd0, 3'd0, 6'd3, 7'd1, 16'h0);
    wait_end(100);
    chk("post_rst_rd", word_at(b0), 16'hA5C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
